// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU with status flags,
// invalid-op detection and an iterative one-bit-per-cycle shifter.
//
// Ports:
//   i_clock, i_reset        clock (rising edge), async active-high reset
//   i_valid / o_ready       upstream handshake (A, B, opcode)
//   i_data_a, i_data_b      operands (B is the unsigned shift amount)
//   i_op                    opcode
//   o_valid / i_ready       downstream handshake (result and flags)
//   o_result                result
//   o_zero, o_negative      result == 0, result MSB
//   o_carry, o_overflow     carry/borrow/last bit out, signed overflow
//   o_error                 opcode not recognised
module alu_seq #(
  parameter int NB_DATA      = 8,
  parameter int NB_OPERATION = 6,
  parameter int NB_COUNT     = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NB_DATA-1:0]      i_data_a,
  input  logic [NB_DATA-1:0]      i_data_b,
  input  logic [NB_OPERATION-1:0] i_op,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NB_DATA-1:0]      o_result,
  output logic                    o_zero,
  output logic                    o_negative,
  output logic                    o_carry,
  output logic                    o_overflow,
  output logic                    o_error
);

  localparam int MSB = NB_DATA - 1;

  localparam logic [NB_OPERATION-1:0] OP_ADD = NB_OPERATION'(6'b100000);
  localparam logic [NB_OPERATION-1:0] OP_SUB = NB_OPERATION'(6'b100010);
  localparam logic [NB_OPERATION-1:0] OP_AND = NB_OPERATION'(6'b100100);
  localparam logic [NB_OPERATION-1:0] OP_OR  = NB_OPERATION'(6'b100101);
  localparam logic [NB_OPERATION-1:0] OP_XOR = NB_OPERATION'(6'b100110);
  localparam logic [NB_OPERATION-1:0] OP_NOR = NB_OPERATION'(6'b100111);
  localparam logic [NB_OPERATION-1:0] OP_SRA = NB_OPERATION'(6'b000011);
  localparam logic [NB_OPERATION-1:0] OP_SRL = NB_OPERATION'(6'b000010);
  localparam logic [NB_OPERATION-1:0] OP_SLL = NB_OPERATION'(6'b000000);

  localparam logic [NB_DATA-1:0]  W_LIM = NB_DATA'(NB_DATA);
  localparam logic [NB_COUNT-1:0] CNT_1 = NB_COUNT'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    SH_SRA,
    SH_SRL,
    SH_SLL
  } shkind_t;

  state_t  state, state_n;
  shkind_t kind, kind_n;

  logic [NB_DATA-1:0]  work, work_n;
  logic [NB_COUNT-1:0] cnt;
  logic                out_n;

  logic [NB_DATA:0]    sum, diff;
  logic [NB_DATA-1:0]  res_n;
  logic                c_n, v_n, e_n, iter;
  logic                b_zero, b_big;

  logic accept, load_hold, load_shift, step, finish;

  assign o_ready = ~i_reset &
                   ((state == IDLE) | ((state == HOLD) & i_ready));
  assign accept  = i_valid & o_ready;
  assign o_valid = (state == HOLD);

  assign sum    = {1'b0, i_data_a} + {1'b0, i_data_b};
  assign diff   = {1'b0, i_data_a} - {1'b0, i_data_b};
  assign b_zero = (i_data_b == '0);
  assign b_big  = (i_data_b >= W_LIM);

  // Single-cycle result, or a request to start the iterative shifter.
  always_comb begin
    res_n  = '0;
    c_n    = 1'b0;
    v_n    = 1'b0;
    e_n    = 1'b0;
    iter   = 1'b0;
    kind_n = SH_SRL;
    unique case (i_op)
      OP_ADD: begin
        res_n = sum[MSB:0];
        c_n   = sum[NB_DATA];
        v_n   = (i_data_a[MSB] == i_data_b[MSB]) &
                (sum[MSB] != i_data_a[MSB]);
      end
      OP_SUB: begin
        res_n = diff[MSB:0];
        c_n   = diff[NB_DATA];
        v_n   = (i_data_a[MSB] != i_data_b[MSB]) &
                (diff[MSB] != i_data_a[MSB]);
      end
      OP_AND: res_n = i_data_a & i_data_b;
      OP_OR:  res_n = i_data_a | i_data_b;
      OP_XOR: res_n = i_data_a ^ i_data_b;
      OP_NOR: res_n = ~(i_data_a | i_data_b);
      OP_SRA: begin
        kind_n = SH_SRA;
        if (b_zero)     res_n = i_data_a;
        else if (b_big) res_n = {NB_DATA{i_data_a[MSB]}};
        else            iter  = 1'b1;
      end
      OP_SRL: begin
        kind_n = SH_SRL;
        if (b_zero)     res_n = i_data_a;
        else if (b_big) res_n = '0;
        else            iter  = 1'b1;
      end
      OP_SLL: begin
        kind_n = SH_SLL;
        if (b_zero)     res_n = i_data_a;
        else if (b_big) res_n = '0;
        else            iter  = 1'b1;
      end
      default: begin
        res_n = '1;
        e_n   = 1'b1;
      end
    endcase
  end

  // One-bit shift step of the working register.
  always_comb begin
    work_n = {1'b0, work[MSB:1]};
    out_n  = work[0];
    unique case (kind)
      SH_SRA: begin
        work_n = {work[MSB], work[MSB:1]};
        out_n  = work[0];
      end
      SH_SLL: begin
        work_n = {work[MSB-1:0], 1'b0};
        out_n  = work[MSB];
      end
      default: begin
        work_n = {1'b0, work[MSB:1]};
        out_n  = work[0];
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load_hold  = 1'b0;
    load_shift = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (iter) begin
            state_n    = SHIFT;
            load_shift = 1'b1;
          end else begin
            state_n   = HOLD;
            load_hold = 1'b1;
          end
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_1) begin
          state_n = HOLD;
          finish  = 1'b1;
        end
      end
      HOLD: begin
        if (accept) begin
          if (iter) begin
            state_n    = SHIFT;
            load_shift = 1'b1;
          end else begin
            state_n   = HOLD;
            load_hold = 1'b1;
          end
        end else if (i_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Result and flags only change on a transfer into HOLD.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      work       <= '0;
      cnt        <= '0;
      kind       <= SH_SRL;
      o_result   <= '0;
      o_zero     <= 1'b0;
      o_negative <= 1'b0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_error    <= 1'b0;
    end else if (load_hold) begin
      o_result   <= res_n;
      o_zero     <= (res_n == '0);
      o_negative <= res_n[MSB];
      o_carry    <= c_n;
      o_overflow <= v_n;
      o_error    <= e_n;
    end else if (load_shift) begin
      work <= i_data_a;
      cnt  <= NB_COUNT'(i_data_b);
      kind <= kind_n;
    end else if (step) begin
      work <= work_n;
      cnt  <= cnt - CNT_1;
      if (finish) begin
        o_result   <= work_n;
        o_zero     <= (work_n == '0);
        o_negative <= work_n[MSB];
        o_carry    <= out_n;
        o_overflow <= 1'b0;
        o_error    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked successor of the combinational datapath ALU, parametrised in data width.
- Adds status flags, invalid-op detection, SLL, and an iterative one-bit-per-cycle shifter (variable latency) in place of the flat shift mux.
- Sits between the operand/opcode latch stage and the result register/display stage.
- Valid/ready on both sides, so it can be stalled by downstream logic.

Parameters:
- NB_DATA, 8, operand/result width in bits (>=4).
- NB_OPERATION, 6, opcode width in bits.
- NB_COUNT, 4, shift-counter width in bits; must satisfy 2**NB_COUNT > NB_DATA.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  operands/opcode valid.
- o_ready  output  1  block can accept an operation this cycle.
- i_data_a  input  NB_DATA  operand A (shift source).
- i_data_b  input  NB_DATA  operand B (shift amount, unsigned).
- i_op  input  NB_OPERATION  opcode.
- o_valid  output  1  result and flags valid.
- i_ready  input  1  downstream accepts result.
- o_result  output  NB_DATA  result.
- o_zero  output  1  result == 0.
- o_negative  output  1  result MSB.
- o_carry  output  1  carry/borrow/last bit shifted out.
- o_overflow  output  1  signed overflow.
- o_error  output  1  opcode not recognised.

Behaviour:
- Opcodes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRA 000011, SRL 000010, SLL 000000.
  - Any other value is invalid.
- Reset (asynchronous, any state, including mid-shift):
  - State goes to IDLE; any in-flight operation is dropped.
  - o_result=0; o_valid, o_zero, o_negative, o_carry, o_overflow, o_error all 0.
  - o_ready=0 while i_reset is high.
- FSM states: IDLE, SHIFT, HOLD.
- o_ready = (state==IDLE) | (state==HOLD & i_ready). Combinational; it is low in SHIFT.
- Accept occurs when i_valid & o_ready at a rising edge.
  - A, B and op are captured at that edge; later input changes have no effect.
- Single-cycle ops (all logic/arith ops, invalid ops, and shifts with B==0 or B>=NB_DATA):
  - Result and flags are registered at the accept edge; go to HOLD with o_valid=1.
  - o_valid is therefore seen in the cycle after accept.
- Iterative shifts (SRA/SRL/SLL with 1<=B<=NB_DATA-1):
  - The accept edge loads the working register with A and the counter with B[NB_COUNT-1:0]; go to SHIFT with o_valid=0.
  - Each edge in SHIFT shifts by one bit (SRA replicates the MSB; SRL/SLL fill with zero) and decrements the counter.
  - The edge on which the counter reaches 0 goes to HOLD with o_valid=1.
  - Total: o_valid rises B+1 edges after accept.
- Large shift amounts (B>=NB_DATA):
  - SRL/SLL result = 0.
  - SRA result = all copies of A's MSB.
  - carry = 0.
- B==0 shift: result = A, carry = 0.
- Flags:
  - zero and negative are always derived from the final result.
  - ADD: carry = unsigned carry-out; overflow = both operand signs equal and result sign differs.
  - SUB: carry = borrow (A<B unsigned); overflow = operand signs differ and result sign differs from A.
  - Shifts: carry = last bit shifted out; overflow = 0.
  - Logic ops: carry = 0, overflow = 0.
- NOR is the true ~(A|B).
- Invalid op: result = all ones, o_error=1, carry=0, overflow=0, negative=1, zero=0.
- o_error is 0 for every valid op.
- HOLD:
  - o_result, flags and o_valid are held stable while i_ready=0.
  - i_ready=1 with no new accept: go to IDLE, o_valid=0 on the next edge.
  - i_ready=1 with a simultaneous accept: the new op is processed in the same edge (back-to-back, no bubble).
- Results and flags change only on a transfer into HOLD or on reset.

Test Plan (NB_DATA=8):
- ADD A=0x7F B=0x01, i_ready=1 -> o_valid one cycle after accept; result 0x80, overflow=1, negative=1, carry=0, zero=0.
- SUB A=0x05 B=0x07 -> result 0xFE, carry=1, overflow=0, negative=1. Then ADD 0xFF+0x01 back-to-back with no bubble -> 0x00, carry=1, zero=1.
- SRA A=0x80 B=3:
  - o_ready=0 for 3 cycles; o_valid 4 edges after accept; result 0xF0, carry=0.
  - Follow with SRL A=0x81 B=1 -> 0x40, carry=1, latency 2.
  - Follow with SLL A=0x81 B=1 -> 0x02, carry=1.
- Large shifts with B=9: SRA A=0x80 -> 0xFF; SRL A=0x80 -> 0x00, zero=1. Both single-cycle, carry=0.
- NOR A=0x0F B=0xF0 -> 0x00, zero=1. Invalid op 6'b111111 -> result 0xFF, o_error=1.
- Robustness:
  - Hold i_ready=0 for 5 cycles in HOLD: result and flags stable, o_ready=0.
  - Change inputs during SHIFT: no effect on the result.
  - Assert i_reset mid-SHIFT (SRL B=7, after 3 cycles): all outputs go to 0 immediately; after release, a new ADD completes normally.
